// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : request FSM state encoding
//   NOP_INSTR     : instruction presented to decode whenever IF/ID is empty
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // first cycle out of reset, no request yet
        REQ  = 2'd1,  // imem_req high, waiting for grant
        WAIT = 2'd2,  // one request outstanding, waiting for rvalid
        HOLD = 2'd3   // buffers full, no request until skid drains
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry instruction buffer between fetch and decode.
// Entry 0 is the IF/ID register seen by decode; entry 1 is a skid slot that
// catches a response arriving while decode is stalled.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   flush           drop both entries (taken branch)
//   stall           decode cannot accept; IF/ID holds
//   push            new instruction from memory
//   push_instr/pc   payload of push
//   out_valid/instr/pc   IF/ID contents (instr = NOP when empty)
//   skid_valid      skid slot occupied
//   skid_full_next  skid slot will be occupied next cycle
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            push,
    input  logic [31:0]     push_instr,
    input  logic [XLEN-1:0] push_pc,
    output logic            out_valid,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            skid_valid,
    output logic            skid_full_next
);

    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic            advance;
    logic            skid_load;

    // IF/ID may take a new entry when decode consumes it or it is empty.
    assign advance = !stall || !out_valid;

    // A push lands in the skid when IF/ID is held, or when the skid is
    // itself moving into IF/ID this cycle (keeps order).
    assign skid_load = push && !flush && (!advance || skid_valid);

    always_comb begin
        skid_full_next = 1'b0;
        if (!flush) begin
            if (advance) skid_full_next = skid_valid && push;
            else         skid_full_next = skid_valid || push;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            out_pc    <= '0;
        end else if (advance) begin
            if (skid_valid) begin
                out_valid <= 1'b1;
                out_instr <= skid_instr;
                out_pc    <= skid_pc;
            end else if (push) begin
                out_valid <= 1'b1;
                out_instr <= push_instr;
                out_pc    <= push_pc;
            end else begin
                // consumed with nothing behind it; pc is left as-is
                out_valid <= 1'b0;
                out_instr <= NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
        end else begin
            skid_valid <= skid_full_next;
            if (skid_load) begin
                skid_instr <= push_instr;
                skid_pc    <= push_pc;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues one outstanding read at a
// time to instruction memory and hands instructions to decode through
// fetch_skid_buf. A taken branch (pc_sel) redirects the PC, flushes the
// buffer and discards a response still in flight.
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   pc_sel, branch_target       redirect request and target (bits[1:0] ignored)
//   stall                       decode back-pressure
//   imem_req/addr/gnt           request handshake (req & gnt)
//   imem_rvalid/rdata           one response per accepted request
//   if_valid/if_instr/if_pc     IF/ID register towards decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            drop, drop_nxt;
    logic [XLEN-1:0] target;
    logic            push;
    logic            skid_valid;
    logic            skid_full_next;

    assign target    = branch_target & ALIGN_MASK;
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    // Responses count only while waiting for one; anything seen in IDLE,
    // REQ or HOLD is a leftover from before a reset and is ignored.
    assign push = imem_rvalid && (state == WAIT) && !drop && !pc_sel;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        if (pc_sel) begin
            pc_nxt    = target;
            drop_nxt  = 1'b0;
            state_nxt = REQ;
            case (state)
                // old address was accepted this cycle: its data must be dropped
                REQ:  if (imem_gnt) begin
                          state_nxt = WAIT;
                          drop_nxt  = 1'b1;
                      end
                // response not yet back: wait for it and throw it away
                WAIT: if (!imem_rvalid) begin
                          state_nxt = WAIT;
                          drop_nxt  = 1'b1;
                      end
                default: ;
            endcase
        end else begin
            case (state)
                IDLE: state_nxt = REQ;
                REQ:  if (imem_gnt) begin
                          state_nxt = WAIT;
                          pc_nxt    = pc + PC_STEP;
                      end
                WAIT: if (imem_rvalid) begin
                          drop_nxt  = 1'b0;
                          state_nxt = (drop || !skid_full_next) ? REQ : HOLD;
                      end
                HOLD: if (!skid_valid) state_nxt = REQ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            drop  <= drop_nxt;
        end
    end

    // In WAIT without a redirect, pc already points one word past the
    // outstanding request, so the response address is pc - 4.
    fetch_skid_buf #(
        .XLEN(XLEN)
    ) u_buf (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (pc_sel),
        .stall          (stall),
        .push           (push),
        .push_instr     (imem_rdata),
        .push_pc        (pc - PC_STEP),
        .out_valid      (if_valid),
        .out_instr      (if_instr),
        .out_pc         (if_pc),
        .skid_valid     (skid_valid),
        .skid_full_next (skid_full_next)
    );

endmodule
